// File: rtl/de1_soc_alternative_hps_master_b2p.sv
// Byte-stream to packet decoder for the alternative HPS master.
// Strips SOP/EOP/channel/escape framing from an Avalon-ST byte stream and
// emits registered Avalon-ST beats with packet and channel sidebands.
module de1_soc_alternative_hps_master_b2p #(
    parameter int unsigned CHANNEL_WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [7:0]               in_data_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [7:0]               out_data_o,
    output logic                     out_startofpacket_o,
    output logic                     out_endofpacket_o,
    output logic [CHANNEL_WIDTH-1:0] out_channel_o
);

    localparam logic [7:0] SopCode  = 8'h7A;
    localparam logic [7:0] EopCode  = 8'h7B;
    localparam logic [7:0] ChanCode = 8'h7C;
    localparam logic [7:0] EscCode  = 8'h7D;
    localparam logic [7:0] EscXor   = 8'h20;

    // Output beat register
    logic                     out_valid_q, out_valid_d;
    logic [7:0]               out_data_q, out_data_d;
    logic                     out_sop_q, out_sop_d;
    logic                     out_eop_q, out_eop_d;
    logic [CHANNEL_WIDTH-1:0] out_chan_q, out_chan_d;

    // Decoder state
    logic                     esc_pend_q, esc_pend_d;
    logic                     chan_pend_q, chan_pend_d;
    logic                     sop_pend_q, sop_pend_d;
    logic                     eop_pend_q, eop_pend_d;
    logic [CHANNEL_WIDTH-1:0] cur_chan_q, cur_chan_d;

    logic       in_ready;
    logic       accept;
    logic       is_data;
    logic       is_chan;
    logic [7:0] dec_byte;

    // Handshake, byte classification and next-state for beat and decoder state
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        out_chan_d  = out_chan_q;
        esc_pend_d  = esc_pend_q;
        chan_pend_d = chan_pend_q;
        sop_pend_d  = sop_pend_q;
        eop_pend_d  = eop_pend_q;
        cur_chan_d  = cur_chan_q;
        is_data     = 1'b0;
        is_chan     = 1'b0;
        dec_byte    = in_data_i;

        // Accept only when the output slot is free or draining this cycle
        in_ready = reset_ni && (!out_valid_q || out_ready_i);
        accept   = in_valid_i && in_ready;

        if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            if (esc_pend_q) begin
                // Escaped value is never matched against special codes
                dec_byte   = in_data_i ^ EscXor;
                esc_pend_d = 1'b0;
                if (chan_pend_q) begin
                    is_chan = 1'b1;
                end else begin
                    is_data = 1'b1;
                end
            end else begin
                case (in_data_i)
                    EscCode:  esc_pend_d = 1'b1;
                    SopCode: begin
                        sop_pend_d  = 1'b1;
                        chan_pend_d = 1'b0;
                    end
                    EopCode: begin
                        eop_pend_d  = 1'b1;
                        chan_pend_d = 1'b0;
                    end
                    ChanCode: chan_pend_d = 1'b1;
                    default: begin
                        if (chan_pend_q) begin
                            is_chan = 1'b1;
                        end else begin
                            is_data = 1'b1;
                        end
                    end
                endcase
            end

            if (is_chan) begin
                cur_chan_d  = CHANNEL_WIDTH'(dec_byte);
                chan_pend_d = 1'b0;
            end

            if (is_data) begin
                out_valid_d = 1'b1;
                out_data_d  = dec_byte;
                out_sop_d   = sop_pend_q;
                out_eop_d   = eop_pend_q;
                out_chan_d  = cur_chan_q;
                sop_pend_d  = 1'b0;
                eop_pend_d  = 1'b0;
            end
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_chan_q  <= '0;
            esc_pend_q  <= 1'b0;
            chan_pend_q <= 1'b0;
            sop_pend_q  <= 1'b0;
            eop_pend_q  <= 1'b0;
            cur_chan_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            out_chan_q  <= out_chan_d;
            esc_pend_q  <= esc_pend_d;
            chan_pend_q <= chan_pend_d;
            sop_pend_q  <= sop_pend_d;
            eop_pend_q  <= eop_pend_d;
            cur_chan_q  <= cur_chan_d;
        end
    end

    assign in_ready_o          = in_ready;
    assign out_valid_o         = out_valid_q;
    assign out_data_o          = out_data_q;
    assign out_startofpacket_o = out_sop_q;
    assign out_endofpacket_o   = out_eop_q;
    assign out_channel_o       = out_chan_q;

endmodule

// File: doc/de1_soc_alternative_hps_master_b2p.md
# de1_soc_alternative_hps_master_b2p

Byte-stream-to-packet decoder for the alternative HPS master. It consumes the 8-bit Avalon-ST byte stream leaving the master's timing adapter. It strips the in-band framing characters (SOP, EOP, channel, escape) and emits Avalon-ST data beats with startofpacket, endofpacket and channel sidebands to the packet-to-transaction stage. Output is registered, with full backpressure support and one beat per cycle sustained throughput.

## Interface
- CHANNEL_WIDTH, 8: width of out_channel; channel byte is truncated to its low CHANNEL_WIDTH bits.
- clk  in  1  sole clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input byte valid.
- in_ready  out  1  input byte accepted when in_valid && in_ready.
- in_data  in  8  encoded byte stream.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts beat when out_valid && out_ready.
- out_data  out  8  decoded payload byte.
- out_startofpacket  out  1  beat is first of packet.
- out_endofpacket  out  1  beat is last of packet.
- out_channel  out  CHANNEL_WIDTH  channel in effect when the beat's byte was accepted.

## Operation
- Special bytes (unescaped): 0x7A = SOP, 0x7B = EOP, 0x7C = CHANNEL, 0x7D = ESCAPE.
- Internal flags: esc_pend, chan_pend, sop_pend, eop_pend; channel register cur_chan.
- Decode of each accepted byte b, first match wins:
  - esc_pend=1: v = b ^ 0x20; clear esc_pend; v is treated as a channel byte if chan_pend=1, otherwise as data. Special-code matching is not applied to v.
  - b=0x7D: set esc_pend. chan_pend is unchanged, so the channel byte may be escaped.
  - b=0x7A: set sop_pend; clear chan_pend.
  - b=0x7B: set eop_pend; clear chan_pend.
  - b=0x7C: set chan_pend.
  - chan_pend=1: cur_chan <= b[CHANNEL_WIDTH-1:0]; clear chan_pend. No beat is emitted.
  - otherwise (data): load the output register with out_data=b, out_startofpacket=sop_pend, out_endofpacket=eop_pend, out_channel=cur_chan; set out_valid; clear sop_pend and eop_pend.
- Special and channel bytes produce no output beat.
- A channel byte updates cur_chan without touching the output register. A beat already held keeps its captured channel.
- Repeated SOP or EOP before a data byte is idempotent.
- SOP and EOP may both be pending, giving a single-beat packet.
- No packet-state checking: a missing SOP or EOP is passed through as-is and no error is raised.

## Timing
- Reset (reset_n=0, async):
  - out_valid=0, out_data=0, out_startofpacket=0, out_endofpacket=0, out_channel=0.
  - All flags = 0; cur_chan = 0.
  - in_ready=0 while reset_n=0.
- in_ready = reset_n && (!out_valid || out_ready), combinational. No input-to-input combinational path other than via out_ready.
- Latency: a data byte accepted at edge N gives out_valid=1 with its sidebands after edge N (visible in cycle N+1).
- Throughput: one data byte per cycle when out_ready is held high.
- Simultaneous accept-in and drain-out in the same cycle:
  - Data byte: the output register reloads and out_valid stays 1.
  - Non-data byte: out_valid falls to 0.
- Held beat (out_valid=1, out_ready=0):
  - out_* are stable and in_ready=0.
  - Flags and cur_chan do not change because no input is accepted.
- Reset asserted mid-packet: the held beat is discarded and all pending flags and the channel clear. Decode restarts clean after deassertion.
- Reset is released synchronously by the upstream reset synchronizer; no extra in-block synchronization.

## Test plan
- Basic packet: 7A 7C 03 11 22 7B 33, out_ready=1 -> beats:
  - 11 (sop=1, eop=0, ch=3)
  - 22 (sop=0, eop=0, ch=3)
  - 33 (sop=0, eop=1, ch=3)
  - Each beat one cycle after its byte; no beats for 7A, 7C, 03, 7B.
- Escapes: 7A 7D 5A 7D 5D 7B 7D 5B -> beats:
  - 7A (sop=1)
  - 7D
  - 7B (eop=1)
  - Escaped channel 7C 7D 5C followed by 44 -> beat 44 with ch=0x7C.
- Backpressure: stream 7A 01 02 03 7B 04 with out_ready toggled 1,0,0,1,0,1…:
  - in_ready low whenever a beat is held.
  - No beat lost or duplicated; order 01..04 preserved.
  - Sidebands stable while held.
- Single-beat packet and cancellation:
  - 7A 7B 55 -> one beat 55 (sop=1, eop=1).
  - 7C 7A 66 -> beat 66 with sop=1 and channel unchanged (chan_pend cancelled).
- Reset mid-packet: 7A 7C 05 AA, assert reset_n=0 while beat AA is held with out_ready=0:
  - Outputs go to 0 immediately.
  - After release, 77 -> beat 77 with sop=0, ch=0.
- Full-rate random: 10k random bytes with random in_valid and out_ready, checked against a reference decoder model. Output stream must match exactly.
